// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared types and constants for the bus master port
// Purpose: controller state encoding, slave id constants, mode constants and
//   a small constant helper used for counter sizing.
// Ports: none (package).
package bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_ADDR,
    ST_WDATA,
    ST_ACK_WAIT,
    ST_RD_WAIT,
    ST_DONE
  } bus_state_e;

  localparam logic [1:0] SLV_0    = 2'd0;
  localparam logic [1:0] SLV_1    = 2'd1;
  localparam logic [1:0] SLV_2    = 2'd2;
  localparam logic [1:0] SLV_RSVD = 2'd3;

  localparam logic MODE_WRITE = 1'b1;
  localparam logic MODE_READ  = 1'b0;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bus_master_port_if.sv
// rtl/bus_master_port_if.sv - master-to-arbiter/slave serial bus bundle
// Purpose: groups request/grant handshake and serial data lines of one master.
// Signals: m_request, m_slave_sel[1:0], m_grant, m_dout, m_dvalid, m_mode,
//   m_din, m_din_valid, m_ack. Modport master drives request side; modport
//   slave is the arbiter/slave view.
interface bus_master_port_if;
  logic       m_request;
  logic [1:0] m_slave_sel;
  logic       m_grant;
  logic       m_dout;
  logic       m_dvalid;
  logic       m_mode;
  logic       m_din;
  logic       m_din_valid;
  logic       m_ack;

  modport master (
    output m_request, m_slave_sel, m_dout, m_dvalid, m_mode,
    input  m_grant, m_din, m_din_valid, m_ack
  );

  modport slave (
    input  m_request, m_slave_sel, m_dout, m_dvalid, m_mode,
    output m_grant, m_din, m_din_valid, m_ack
  );
endinterface

// File: rtl/bus_shift_reg.sv
// rtl/bus_shift_reg.sv - parallel-load, shift-right register
// Purpose: loads a word in parallel or shifts right by one with din entering
//   the MSB; q[0] is the next bit out (LSB-first serial order).
// Ports: clk, rst (async, active-high), load, load_data[W], shift_en, din,
//   q[W] register contents.
module bus_shift_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         shift_en,
  input  logic         din,
  output logic [W-1:0] q
);

  logic [W-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load) begin
      sr_d = load_data;
    end else if (shift_en) begin
      sr_d = {din, sr_q[W-1:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign q = sr_q;

endmodule

// File: rtl/bus_master_port.sv
// rtl/bus_master_port.sv - master-side serial bus port for the two-master arbiter
// Purpose: accepts one read/write command, requests the arbiter, shifts the
//   address (and write data) out LSB first, then collects serial read data or
//   waits for the write acknowledge. Optional wait timeout: BUS_TIMEOUT_EN.
// Ports: clk, rst (async, active-high); cmd_start/cmd_write/cmd_slave/
//   cmd_addr/cmd_wdata command inputs; busy, done, err, rdata status outputs;
//   bus (bus_master_port_if.master) request/grant and serial data lines.
module bus_master_port
  import bus_pkg::*;
#(
  parameter int ADDR_W         = 12,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_start,
  input  logic              cmd_write,
  input  logic [1:0]        cmd_slave,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  bus_master_port_if.master bus
);

  localparam int OUT_W = ADDR_W + DATA_W;
  localparam int CNT_W = $clog2(max_int(ADDR_W, DATA_W) + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  bus_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mode_q, mode_d;
  logic [1:0]        slave_q, slave_d;
  logic              busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic              req_q, req_d, dvalid_q, dvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              load_out, shift_out, shift_in, timeout;
  logic [OUT_W-1:0]  out_q;
  logic [DATA_W-1:0] in_q;
  logic              shift_unused;

`ifdef BUS_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_ONE = 1;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            waiting;

  assign waiting = (state_q == ST_REQ) || (state_q == ST_ACK_WAIT) || (state_q == ST_RD_WAIT);
  assign timeout = waiting && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  // Restart on every state change; each received read bit also restarts it.
  always_comb begin
    to_cnt_d = to_cnt_q;
    if ((state_d != state_q) || ((state_q == ST_RD_WAIT) && bus.m_din_valid)) begin
      to_cnt_d = '0;
    end else if (waiting) begin
      to_cnt_d = to_cnt_q + TO_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  localparam int TIMEOUT_UNUSED = TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  // Address and write data share one register: {wdata, addr} drains LSB first.
  bus_shift_reg #(.W(OUT_W)) u_out_sr (
    .clk       (clk),
    .rst       (rst),
    .load      (load_out),
    .load_data ({cmd_wdata, cmd_addr}),
    .shift_en  (shift_out),
    .din       (1'b0),
    .q         (out_q)
  );

  bus_shift_reg #(.W(DATA_W)) u_in_sr (
    .clk       (clk),
    .rst       (rst),
    .load      (1'b0),
    .load_data ('0),
    .shift_en  (shift_in),
    .din       (bus.m_din),
    .q         (in_q)
  );

  assign shift_unused = ^{out_q[OUT_W-1:1], in_q[0]};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    slave_d   = slave_q;
    rdata_d   = rdata_q;
    err_d     = 1'b0;
    load_out  = 1'b0;
    shift_out = 1'b0;
    shift_in  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_start) begin
          mode_d   = cmd_write;
          slave_d  = cmd_slave;
          load_out = 1'b1;
          if (cmd_slave == SLV_RSVD) begin
            state_d = ST_DONE;
            err_d   = 1'b1;
          end else begin
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (bus.m_grant) begin
          state_d = ST_ADDR;
        end else if (timeout) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end
      end
      ST_ADDR, ST_WDATA: begin
        if (!bus.m_grant) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end else begin
          shift_out = 1'b1;
          cnt_d     = cnt_q + CNT_ONE;
          if ((state_q == ST_ADDR) && (cnt_q == CNT_W'(ADDR_W - 1))) begin
            state_d = (mode_q == MODE_WRITE) ? ST_WDATA : ST_RD_WAIT;
          end else if ((state_q == ST_WDATA) && (cnt_q == CNT_W'(DATA_W - 1))) begin
            state_d = ST_ACK_WAIT;
          end
        end
      end
      ST_ACK_WAIT: begin
        if (!bus.m_grant) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end else if (bus.m_ack) begin
          state_d = ST_DONE;
        end else if (timeout) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end
      end
      ST_RD_WAIT: begin
        if (!bus.m_grant) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end else if (bus.m_din_valid) begin
          shift_in = 1'b1;
          cnt_d    = cnt_q + CNT_ONE;
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            state_d = ST_DONE;
            // Publish the completed word including the bit arriving now.
            rdata_d = {bus.m_din, in_q[DATA_W-1:1]};
          end
        end else if (timeout) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
    end

    // Outputs are decoded from the next state so they are registered in step.
    busy_d   = (state_d != ST_IDLE);
    done_d   = (state_d == ST_DONE);
    req_d    = state_d inside {ST_REQ, ST_ADDR, ST_WDATA, ST_ACK_WAIT, ST_RD_WAIT};
    dvalid_d = state_d inside {ST_ADDR, ST_WDATA};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      mode_q   <= MODE_READ;
      slave_q  <= SLV_0;
      rdata_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      req_q    <= 1'b0;
      dvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      slave_q  <= slave_d;
      rdata_q  <= rdata_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      req_q    <= req_d;
      dvalid_q <= dvalid_d;
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign err             = err_q;
  assign rdata           = rdata_q;
  assign bus.m_request   = req_q;
  assign bus.m_slave_sel = req_q ? slave_q : SLV_0;
  assign bus.m_dvalid    = dvalid_q;
  assign bus.m_dout      = dvalid_q & out_q[0];
  assign bus.m_mode      = dvalid_q & mode_q;

endmodule

// File: tb/tb_bus_master_port.sv
// tb/tb_bus_master_port.sv - self-checking bench for bus_master_port
module tb_bus_master_port;
  import bus_pkg::*;

  localparam int AW = 12;
  localparam int DW = 8;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_start = 1'b0;
  logic          cmd_write = 1'b0;
  logic [1:0]    cmd_slave = 2'd0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          busy, done, err;
  logic [DW-1:0] rdata;
  logic [DW-1:0] rdata_model = '0;

  int vectors = 0;
  int miscompares = 0;

  bus_master_port_if bus_if ();

  bus_master_port #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_start (cmd_start),
    .cmd_write (cmd_write),
    .cmd_slave (cmd_slave),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .bus       (bus_if)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] all_outputs();
    return {15'd0, busy, done, err, rdata, bus_if.m_request, bus_if.m_slave_sel,
            bus_if.m_dout, bus_if.m_dvalid, bus_if.m_mode};
  endfunction

  task automatic start_cmd(input logic w, input logic [1:0] s, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
    cmd_start = 1'b1; cmd_write = w; cmd_slave = s; cmd_addr = a; cmd_wdata = d;
    tick();
    cmd_start = 1'b0;
    cmd_write = 1'($urandom); cmd_slave = 2'($urandom);
    cmd_addr = AW'($urandom); cmd_wdata = DW'($urandom);
  endtask

  // Full transfer; expected serial stream is the address then the data, LSB first.
  task automatic run_xfer(input logic w, input logic [1:0] s, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input int gdly, input int ackdly,
                          input int gap_max, input bit disturb);
    logic [31:0] coll;
    logic [31:0] exp_stream;
    int nbits, nvalid;
    start_cmd(w, s, a, d);
    check("busy_after_start", busy, 1);
    check("req_asserted", bus_if.m_request, 1);
    check("slave_sel", bus_if.m_slave_sel, s);
    repeat (gdly) begin
      bus_if.m_din_valid = 1'($urandom); bus_if.m_din = 1'($urandom);
      tick();
    end
    check("req_before_grant", {bus_if.m_request, bus_if.m_dvalid}, 2'b10);
    bus_if.m_grant = 1'b1;
    tick();
    nbits = w ? AW + DW : AW;
    exp_stream = w ? 32'({d, a}) : 32'(a);
    coll = '0; nvalid = 0;
    for (int i = 0; i < nbits; i++) begin
      if (i == 0) check("m_mode", bus_if.m_mode, w);
      if (bus_if.m_dvalid) nvalid++;
      coll[i] = bus_if.m_dout;
      bus_if.m_din_valid = 1'($urandom); bus_if.m_din = 1'($urandom);
      cmd_start = disturb && (i == 3);
      bus_if.m_ack = disturb && (i == 3);
      tick();
    end
    cmd_start = 1'b0; bus_if.m_ack = 1'b0; bus_if.m_din_valid = 1'b0;
    check("dvalid_count", nvalid, nbits);
    check("serial_stream", coll, exp_stream);
    check("after_stream", {bus_if.m_dvalid, bus_if.m_request, done}, 3'b010);
    if (w) begin
      repeat (ackdly) tick();
      bus_if.m_ack = 1'b1;
      tick();
      bus_if.m_ack = 1'b0;
    end else begin
      for (int i = 0; i < DW; i++) begin
        repeat ($urandom_range(gap_max)) begin
          bus_if.m_din_valid = 1'b0; bus_if.m_din = 1'($urandom);
          tick();
        end
        check("no_early_done", done, 0);
        bus_if.m_din_valid = 1'b1; bus_if.m_din = d[i];
        tick();
      end
      bus_if.m_din_valid = 1'b0;
      rdata_model = d;
    end
    check("done_ok", {done, err, bus_if.m_request, busy, bus_if.m_dvalid}, 5'b10010);
    check("rdata_at_done", rdata, rdata_model);
    tick();
    check("idle_after_done", {done, busy}, 2'b00);
    check("rdata_held", rdata, rdata_model);
    bus_if.m_grant = 1'b0;
    tick();
    check("start_during_busy_ignored", busy, 0);
  endtask

  initial begin
    bus_if.m_grant = 1'b0; bus_if.m_din = 1'b0; bus_if.m_din_valid = 1'b0; bus_if.m_ack = 1'b0;
    tick(); tick();
    check("reset_outputs", all_outputs(), 0);
    rst = 1'b0;
    tick();
    check("idle_outputs", all_outputs(), 0);

    // Directed write: slave 1, grant after 2 cycles, ack 3 cycles after last bit.
    run_xfer(1'b1, SLV_1, 12'hA5C, 8'h3C, 2, 3, 0, 1'b0);
    // Directed read with gaps.
    run_xfer(1'b0, SLV_2, 12'h001, 8'hC9, 1, 0, 1, 1'b0);
    // Busy-time start and stray ack during address phase.
    run_xfer(1'b1, SLV_0, 12'h5A3, 8'h81, 0, 1, 0, 1'b1);

    // Grant loss at address bit 5.
    start_cmd(1'b0, SLV_1, 12'h7E4, 8'h00);
    bus_if.m_grant = 1'b1;
    tick();
    repeat (5) tick();
    check("bit5_before_loss", bus_if.m_dout, 1);
    bus_if.m_grant = 1'b0;
    tick();
    check("abort_done_err", {done, err, bus_if.m_dvalid, bus_if.m_request}, 4'b1100);
    check("abort_rdata_kept", rdata, rdata_model);
    tick();
    check("abort_idle", {busy, done}, 2'b00);

    // Reserved slave id.
    start_cmd(1'b1, SLV_RSVD, 12'h123, 8'h45);
    check("rsvd_done_err", {done, err, bus_if.m_request}, 3'b110);
    tick();
    check("rsvd_idle", {done, busy, bus_if.m_request}, 3'b000);

    // Randomized transfers against the reference stream/data model.
    for (int k = 0; k < 8; k++) begin
      run_xfer(1'($urandom), 2'($urandom_range(2)), AW'($urandom), DW'($urandom),
               $urandom_range(3), $urandom_range(4), 2, k[0]);
    end

    // No grant at all.
    start_cmd(1'b0, SLV_0, 12'h0F0, 8'h00);
`ifdef BUS_TIMEOUT_EN
    repeat (TO - 1) tick();
    check("timeout_not_yet", {done, bus_if.m_request}, 2'b01);
    tick();
    check("timeout_done_err", {done, err, bus_if.m_request}, 3'b110);
    tick();
    check("timeout_idle", busy, 0);
    start_cmd(1'b0, SLV_0, 12'h0F0, 8'h00);
`else
    begin
      int held = 0;
      repeat (1000) begin
        if (bus_if.m_request && !done) held++;
        tick();
      end
      check("still_req_1000", held, 1000);
    end
`endif
    rst = 1'b1;
    #1;
    check("rst_mid_outputs", all_outputs(), 0);
    tick();
    rst = 1'b0;
    tick();
    check("no_done_after_rst", all_outputs(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
